// File: rtl/branch_fetch_unit.sv
// MIPS instruction-fetch front end: PC, req/ack fetch port, valid/ready decode port, branch/jump redirect.
// Define BFU_ALIGN_CHECK_EN to reject misaligned redirect targets and raise the sticky misalign flag.
module branch_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic        jump,
    input  logic [31:0] br_pc_plus4,
    input  logic [31:0] br_offset,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_pc;
    logic [31:0] r_dropAddr;
    logic [31:0] r_instr;
    logic [31:0] r_ifPc;
    logic        r_valid;

    logic [31:0] w_brTarget;
    logic [31:0] w_jmpTarget;
    logic [31:0] w_rawTarget;
    logic [31:0] w_target;
    logic        w_redirReq;
    logic        w_redir;
    logic        w_bufFree;
    logic        w_req;
    logic        w_ack;
    logic        w_capture;
    logic        w_enterDrop;

    assign w_brTarget  = br_pc_plus4 + br_offset;
    assign w_jmpTarget = {br_pc_plus4[31:28], jump_index, 2'b00};
    assign w_rawTarget = jump ? w_jmpTarget : w_brTarget;
    assign w_redirReq  = jump | br_taken;

`ifdef BFU_ALIGN_CHECK_EN
    logic w_badTarget;
    logic r_misalign;

    assign w_badTarget = w_redirReq && (w_rawTarget[1:0] != 2'b00);
    assign w_redir     = w_redirReq && !w_badTarget;
    assign w_target    = w_rawTarget;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_badTarget) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign = r_misalign;
`else
    assign w_redir  = w_redirReq;
    assign w_target = w_rawTarget & 32'hFFFF_FFFC;
    assign misalign = 1'b0;
`endif

    // A live request is withheld while the output buffer is full and not draining,
    // so an ack can never overwrite an undelivered instruction.
    assign w_bufFree = !r_valid || if_ready;

    always_comb begin
        w_req = 1'b0;
        case (r_state)
            S_REQ:   w_req = w_bufFree;
            S_DROP:  w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
    end

    assign w_ack = imem_ack && w_req;

    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_enterDrop = 1'b0;
        case (r_state)
            S_REQ: begin
                if (w_ack) begin
                    if (w_redir) begin
                        w_nextState = stall ? S_IDLE : S_REQ;
                    end else begin
                        w_capture = 1'b1;
                        if (!if_ready) begin
                            w_nextState = S_HOLD;
                        end else begin
                            w_nextState = stall ? S_IDLE : S_REQ;
                        end
                    end
                end else if (w_redir && w_req) begin
                    w_enterDrop = 1'b1;
                    w_nextState = S_DROP;
                end else if (!w_req) begin
                    w_nextState = stall ? S_HOLD : S_REQ;
                end
            end
            S_DROP: begin
                if (w_ack) begin
                    w_nextState = stall ? S_IDLE : S_REQ;
                end
            end
            default: begin
                if (w_redir) begin
                    w_nextState = stall ? S_IDLE : S_REQ;
                end else if (!stall && w_bufFree) begin
                    w_nextState = S_REQ;
                end else if (r_valid && !if_ready) begin
                    w_nextState = S_HOLD;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
        endcase
    end

    // The PC always points at the next correct-path fetch; the wrong-path address
    // being drained in DROP is kept separately so imem_addr stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_dropAddr <= RESET_PC;
            r_valid    <= 1'b0;
            r_instr    <= 32'h0;
            r_ifPc     <= 32'h0;
        end else begin
            r_state <= w_nextState;
            if (w_redir) begin
                r_pc <= w_target;
            end else if (w_capture) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_enterDrop) begin
                r_dropAddr <= r_pc;
            end
            if (w_redir) begin
                r_valid <= 1'b0;
            end else if (w_capture) begin
                r_valid <= 1'b1;
            end else if (if_ready) begin
                r_valid <= 1'b0;
            end
            if (w_capture) begin
                r_instr <= imem_data;
                r_ifPc  <= r_pc;
            end
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = (r_state == S_DROP) ? r_dropAddr : r_pc;
    assign if_valid  = r_valid;
    assign if_instr  = r_instr;
    assign if_pc     = r_ifPc;

endmodule

// File: tb/tb_branch_fetch_unit.sv
// Self-checking bench for branch_fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level reference model of program order, redirects and handshakes.
module tb_branch_fetch_unit;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        stall       = 1'b0;
    logic        br_taken    = 1'b0;
    logic        jump        = 1'b0;
    logic [31:0] br_pc_plus4 = 32'h0;
    logic [31:0] br_offset   = 32'h0;
    logic [25:0] jump_index  = 26'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack    = 1'b0;
    logic [31:0] imem_data;
    logic        if_valid;
    logic        if_ready    = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        misalign;

    int checks = 0;
    int errors = 0;

`ifdef BFU_ALIGN_CHECK_EN
    localparam bit AlignCheck = 1'b1;
`else
    localparam bit AlignCheck = 1'b0;
`endif

    branch_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .jump(jump),
        .br_pc_plus4(br_pc_plus4), .br_offset(br_offset), .jump_index(jump_index),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign imem_data = memWord(imem_addr);

    task automatic doReset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        stall = 1'b0; if_ready = 1'b1; imem_ack = 1'b0; br_taken = 1'b0; jump = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr got %h expected 0", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %h expected 0", if_instr); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_ifpc got %h expected 0", if_pc); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign got %b expected 0", misalign); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL first_fetch got req %b addr %h expected req 1 addr 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        stall = 1'b0; if_ready = 1'b1; imem_ack = 1'b1;
        doReset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
                errors++; $display("[TB] FAIL b2b_req[%0d] got req %b addr %h expected req 1 addr %h", i, imem_req, imem_addr, 32'(4 * i));
            end
            checks++; if (if_valid !== (i > 0)) begin
                errors++; $display("[TB] FAIL b2b_valid[%0d] got %b expected %b", i, if_valid, (i > 0));
            end
            if (i > 0) begin
                checks++; if (if_pc !== 32'(4 * (i - 1)) || if_instr !== memWord(32'(4 * (i - 1)))) begin
                    errors++; $display("[TB] FAIL b2b_out[%0d] got pc %h instr %h expected pc %h instr %h",
                                       i, if_pc, if_instr, 32'(4 * (i - 1)), memWord(32'(4 * (i - 1))));
                end
            end
        end
    endtask

    task automatic test_branch_with_ack();
        stall = 1'b0; if_ready = 1'b1; imem_ack = 1'b1;
        doReset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        br_taken = 1'b1; br_pc_plus4 = 32'h0000_0100; br_offset = 32'hFFFF_FFF0;
        @(negedge clk);
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL br_ack_cycle got addr %h expected 8", imem_addr); end
        @(posedge clk); #1; br_taken = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hF0) begin
            errors++; $display("[TB] FAIL br_target got req %b addr %h expected req 1 addr f0", imem_req, imem_addr);
        end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL br_squash got valid %b expected 0", if_valid); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'hF0) begin
            errors++; $display("[TB] FAIL br_deliver got valid %b pc %h expected valid 1 pc f0", if_valid, if_pc);
        end
    endtask

    task automatic test_jump_delayed();
        stall = 1'b0; if_ready = 1'b1; imem_ack = 1'b0;
        doReset();
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        jump = 1'b1; jump_index = 26'h00_0040; br_pc_plus4 = 32'h1000_0008;
        @(negedge clk);
        @(posedge clk); #1; jump = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL jmp_hold got req %b addr %h expected req 1 addr 0", imem_req, imem_addr);
        end
        @(posedge clk); #1; imem_ack = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL jmp_ack_addr got req %b addr %h expected req 1 addr 0", imem_req, imem_addr);
        end
        @(posedge clk); #1; imem_ack = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000_0100 || if_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL jmp_target got req %b addr %h valid %b expected req 1 addr 10000100 valid 0",
                               imem_req, imem_addr, if_valid);
        end
        @(posedge clk); #1; imem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h1000_0100 || if_instr !== memWord(32'h1000_0100)) begin
            errors++; $display("[TB] FAIL jmp_deliver got valid %b pc %h instr %h expected valid 1 pc 10000100 instr %h",
                               if_valid, if_pc, if_instr, memWord(32'h1000_0100));
        end
    endtask

    task automatic test_hold();
        stall = 1'b0; if_ready = 1'b0; imem_ack = 1'b1;
        doReset();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin br_taken = 1'b1; br_pc_plus4 = 32'h40; br_offset = 32'h20; end
            @(negedge clk);
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== memWord(32'h0) || imem_req !== 1'b0) begin
                errors++; $display("[TB] FAIL hold[%0d] got valid %b pc %h instr %h req %b expected 1 0 %h 0",
                                   k, if_valid, if_pc, if_instr, imem_req, memWord(32'h0));
            end
        end
        @(posedge clk); #1; br_taken = 1'b0;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h60) begin
            errors++; $display("[TB] FAIL hold_redirect got valid %b req %b addr %h expected 0 1 60", if_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_stall_branch();
        stall = 1'b1; if_ready = 1'b1; imem_ack = 1'b1;
        doReset();
        @(negedge clk);
        @(posedge clk); #1;
        br_taken = 1'b1; br_pc_plus4 = 32'h100; br_offset = 32'h100;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL stall_idle[%0d] got req %b valid %b expected 0 0", k, imem_req, if_valid);
            end
            @(posedge clk); #1;
            br_taken = 1'b0;
            if (k == 2) stall = 1'b0;
        end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("[TB] FAIL stall_resume got req %b addr %h expected 1 200", imem_req, imem_addr);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] expAddr;
        logic [31:0] expPc;
        stall = 1'b0; if_ready = 1'b1; imem_ack = 1'b1;
        doReset();
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        br_taken = 1'b1; br_pc_plus4 = 32'h40; br_offset = 32'h2;
        @(negedge clk);
        checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL mis_early got %b expected 0", misalign); end
        @(posedge clk); #1; br_taken = 1'b0;
        @(negedge clk);
        expAddr = AlignCheck ? 32'h8 : 32'h40;
        checks++; if (imem_addr !== expAddr || misalign !== AlignCheck) begin
            errors++; $display("[TB] FAIL mis_redirect got addr %h mis %b expected addr %h mis %b", imem_addr, misalign, expAddr, AlignCheck);
        end
        @(negedge clk);
        expPc = AlignCheck ? 32'h8 : 32'h40;
        checks++; if (if_pc !== expPc || misalign !== AlignCheck) begin
            errors++; $display("[TB] FAIL mis_sticky got pc %h mis %b expected pc %h mis %b", if_pc, misalign, expPc, AlignCheck);
        end
    endtask

    task automatic test_reset_mid();
        stall = 1'b0; if_ready = 1'b1; imem_ack = 1'b1;
        doReset();
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1; imem_ack = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0) begin
            errors++; $display("[TB] FAIL mid_reset got req %b addr %h valid %b pc %h expected 0 0 0 0", imem_req, imem_addr, if_valid, if_pc);
        end
        stall = 1'b1; imem_ack = 1'b1;
        @(posedge clk); #1; rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL late_ack[%0d] got req %b valid %b expected 0 0", k, imem_req, if_valid);
            end
        end
        @(posedge clk); #1; stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL post_reset_fetch got req %b addr %h expected 1 0", imem_req, imem_addr);
        end
    endtask

    // Reference model tracks program order only: next correct-path fetch address,
    // next expected delivery, and whether the outstanding request is wrong-path.
    task automatic test_random();
        logic [31:0] mFetch, mDeliver, tgt, rnd, pAddr, pPc, pInstr, pAckAddr;
        logic        stale, mMis, redir, badTgt, pReq, pAcc, pStall, pValid, pReady, pRedir, pLive;
        int          nDeliv;
        stall = 1'b0; if_ready = 1'b1; imem_ack = 1'b0; br_taken = 1'b0; jump = 1'b0;
        doReset();
        mFetch = 32'h0; mDeliver = 32'h0; stale = 1'b0; mMis = 1'b0; nDeliv = 0;
        pReq = 1'b0; pAcc = 1'b0; pStall = 1'b0; pValid = 1'b0; pReady = 1'b0; pRedir = 1'b0; pLive = 1'b0;
        pAddr = 32'h0; pPc = 32'h0; pInstr = 32'h0; pAckAddr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tgt = jump ? ((br_pc_plus4 & 32'hF000_0000) | (32'(jump_index) * 4)) : (br_pc_plus4 + br_offset);
            badTgt = (jump || br_taken) && AlignCheck && (tgt % 4 != 0);
            redir = (jump || br_taken) && !badTgt;
            if (!AlignCheck) tgt = tgt - (tgt % 4);

            checks++; if (misalign !== mMis) begin
                errors++; $display("[TB] FAIL rnd_misalign c%0d got %b expected %b", c, misalign, mMis);
            end
            if (pReq && !pAcc && imem_req) begin
                checks++; if (imem_addr !== pAddr) begin
                    errors++; $display("[TB] FAIL rnd_addr_stable c%0d got %h expected %h", c, imem_addr, pAddr);
                end
            end
            checks++;
            if (pRedir) begin
                if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_squash c%0d got valid %b expected 0", c, if_valid); end
            end else if (pValid && !pReady) begin
                if (if_valid !== 1'b1 || if_pc !== pPc || if_instr !== pInstr) begin
                    errors++; $display("[TB] FAIL rnd_stable c%0d got %b %h %h expected 1 %h %h", c, if_valid, if_pc, if_instr, pPc, pInstr);
                end
            end else if (pLive) begin
                if (if_valid !== 1'b1 || if_pc !== pAckAddr) begin
                    errors++; $display("[TB] FAIL rnd_latency c%0d got valid %b pc %h expected 1 %h", c, if_valid, if_pc, pAckAddr);
                end
            end else begin
                if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_empty c%0d got valid %b expected 0", c, if_valid); end
            end
            if (imem_req && (!pReq || pAcc)) begin
                checks++; if (pStall !== 1'b0) begin
                    errors++; $display("[TB] FAIL rnd_stall_issue c%0d got new req after stall %b expected stall 0", c, pStall);
                end
            end
            if (if_valid && if_ready) begin
                checks++; if (if_pc !== mDeliver || if_instr !== memWord(mDeliver)) begin
                    errors++; $display("[TB] FAIL rnd_deliver c%0d got pc %h instr %h expected pc %h instr %h",
                                       c, if_pc, if_instr, mDeliver, memWord(mDeliver));
                end
                mDeliver = mDeliver + 4;
                nDeliv++;
            end
            pLive = 1'b0;
            if (imem_req && imem_ack) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    checks++; if (imem_addr !== mFetch) begin
                        errors++; $display("[TB] FAIL rnd_fetch_addr c%0d got %h expected %h", c, imem_addr, mFetch);
                    end
                    mFetch = mFetch + 4;
                    pLive = !redir;
                    pAckAddr = imem_addr;
                end
            end
            if (redir) begin
                mFetch = tgt;
                mDeliver = tgt;
                stale = stale | (imem_req && !imem_ack);
            end
            if (badTgt) mMis = 1'b1;
            pReq = imem_req; pAcc = imem_req && imem_ack; pAddr = imem_addr; pStall = stall;
            pValid = if_valid; pReady = if_ready; pPc = if_pc; pInstr = if_instr; pRedir = redir;

            @(posedge clk); #1;
            stall    = ($urandom_range(0, 99) < 20);
            if_ready = ($urandom_range(0, 99) < 70);
            imem_ack = ($urandom_range(0, 99) < 55);
            br_taken = ($urandom_range(0, 99) < 6);
            jump     = ($urandom_range(0, 99) < 4);
            rnd = $urandom();
            br_pc_plus4 = rnd & 32'hFFFF_FFFC;
            rnd = $urandom();
            br_offset = {{14{rnd[15]}}, rnd[15:0], 2'b00};
            if ($urandom_range(0, 49) == 0) br_offset = 32'($urandom_range(1, 3));
            rnd = $urandom();
            jump_index = rnd[25:0];
        end
        checks++; if (nDeliv < 100) begin
            errors++; $display("[TB] FAIL rnd_progress got %0d deliveries expected at least 100", nDeliv);
        end
        br_taken = 1'b0; jump = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at %0t expected completion earlier", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_branch_with_ack();
        test_jump_delayed();
        test_hold();
        test_stall_branch();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_fetch_unit.md
# branch_fetch_unit

Instruction-fetch front end of the MIPS datapath: holds the program counter, issues word fetches to instruction memory over a request/acknowledge handshake, and delivers fetched instructions to decode over a valid/ready handshake. Consumes the already sign-extended, left-shifted branch offset produced by the branch-offset shifter in Execution. Applies branch and jump redirects, squashing in-flight and buffered wrong-path fetches.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; first fetch address.
- `clk`  in  1: sole clock; all state on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stall`  in  1: inhibits issuing new fetch requests.
- `br_taken`  in  1: single-cycle branch-redirect strobe.
- `jump`  in  1: single-cycle jump-redirect strobe.
- `br_pc_plus4`  in  32: PC+4 of the redirecting instruction.
- `br_offset`  in  32: sign-extended immediate shifted left 2.
- `jump_index`  in  26: J-type target index.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address.
- `imem_ack`  in  1: memory accepts request; `imem_data` is valid in the same cycle.
- `imem_data`  in  32: fetched word.
- `if_valid`  out  1: `if_instr`/`if_pc` hold a valid instruction.
- `if_ready`  in  1: decode accepts the instruction.
- `if_instr`  out  32: instruction word.
- `if_pc`  out  32: address of `if_instr`.
- `misalign`  out  1: sticky target-misalignment flag.

## Operation
- Branch target = `br_pc_plus4 + br_offset`, modulo 2^32; overflow wraps silently.
- Jump target = {`br_pc_plus4[31:28]`, `jump_index`, 2'b00}.
- `jump` takes priority over `br_taken` when both are asserted.
- Redirect: the PC loads the target, and every fetch that is not yet delivered is discarded.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding.
  - DROP: outstanding request is wrong-path.
  - HOLD: instruction buffered, waiting on `if_ready`.
- Transitions:
  - IDLE → REQ when `stall`=0 and the output buffer is free or drains this cycle.
  - REQ + `imem_ack`: capture `imem_data` and the PC into the output buffer, then PC += 4. Go to HOLD if decode does not accept, else REQ/IDLE per `stall`.
  - REQ + redirect without ack → DROP.
  - DROP + `imem_ack`: discard data, then REQ at the target (IDLE if `stall`).
  - HOLD + `if_ready`: release the buffer.
  - HOLD + redirect: clear `if_valid` and fetch the target.
- Redirect in the same cycle as `imem_ack`: discard the acked data; next request goes to the target.
- `stall` never aborts an outstanding request. A redirect during `stall` updates the PC; fetch resumes at the target when `stall` drops.
- Reset mid-request: all state clears immediately. A late `imem_ack` after reset, with `imem_req`=0, is ignored.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0.
  - `misalign`=0, PC=`RESET_PC`, state IDLE.
- First cycle after `rst_n` rises: `imem_req`=1, `imem_addr`=`RESET_PC`, unless `stall`.
- `imem_addr` is stable while `imem_req`=1 and no ack has arrived.
- Fetch latency: `if_valid` rises in the cycle after `imem_ack`.
- Zero-wait memory with `if_ready`=1 sustains one instruction per cycle; `imem_req` stays high back-to-back.
- `if_instr`/`if_pc` are stable while `if_valid`=1 and `if_ready`=0.
- Redirect to first target request: 1 cycle from IDLE, REQ-with-ack or HOLD. From DROP, the target request is issued the cycle after the wrong-path ack.

## Configuration
- `BFU_ALIGN_CHECK_EN` defined:
  - A redirect target with bits [1:0] ≠ 0 is ignored; the PC continues sequentially.
  - `misalign` sets the following cycle and stays set until reset.
- `BFU_ALIGN_CHECK_EN` undefined:
  - Target bits [1:0] are forced to 0.
  - `misalign` is tied to 0.

## Test plan
- Reset, zero-wait ack, `if_ready`=1 → `imem_addr` sequence 0x0, 0x4, 0x8; `if_pc` trails by one cycle with matching `imem_data`.
- `br_pc_plus4`=0x100, `br_offset`=0xFFFF_FFF0 (imm 0xFFFC), strobed with ack → next `imem_addr`=0xF0; acked word never reaches `if_valid`.
- Memory ack delayed 3 cycles, `jump`=1 with `jump_index`=0x00_0040 and `br_pc_plus4`=0x1000_0008 in wait cycle 1 → `imem_addr` holds until ack, data dropped, next request 0x1000_0100.
- `if_ready`=0 for 4 cycles after a fetch → `if_instr`/`if_pc` stable, no new request beyond the one fetch. A redirect during the hold deasserts `if_valid` next cycle.
- `stall`=1 with a branch to 0x200 → no request while stalled; `imem_addr`=0x200 one cycle after `stall` drops.
- With `BFU_ALIGN_CHECK_EN`, `br_offset`=0x2 → no redirect, `misalign`=1 next cycle, sequential fetch continues.
